// File: rtl/dsm_ctrl.sv
`timescale 1ns/1ps
// Sample-rate and supervision controller for a delta-sigma modulator:
// paces samples by the oversampling ratio, generates LFSR dither, and recovers the loop on overload.
module dsm_ctrl #(
  parameter int T_BITS      = 16,
  parameter int OSR_BITS    = 8,
  parameter int STALL_LIM   = 64,
  parameter int RECOVER_CYC = 8,
  parameter int DITH_SHIFT  = 10
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     en,
  input  logic [OSR_BITS-1:0]      osr,
  input  logic                     s_valid,
  input  logic signed [T_BITS-1:0] s_data,
  output logic                     s_ready,
  input  logic                     dith_en,
  input  logic [1:0]               pwm,
  input  logic                     ovl_clr,
  output logic signed [T_BITS-1:0] vin,
  output logic signed [T_BITS-1:0] dith,
  output logic                     dsm_reset,
  output logic                     sample_tick,
  output logic                     underrun,
  output logic                     overload
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_LOAD    = 2'd1;
  localparam logic [1:0] S_RUN     = 2'd2;
  localparam logic [1:0] S_RECOVER = 2'd3;

  localparam int RL_W = (STALL_LIM   > 1) ? $clog2(STALL_LIM + 1)   : 1;
  localparam int RC_W = (RECOVER_CYC > 1) ? $clog2(RECOVER_CYC + 1) : 1;

  logic [1:0]          state;
  logic [OSR_BITS-1:0] cnt;
  logic [OSR_BITS-1:0] osr_m1;
  logic [RL_W-1:0]     runlen;
  logic [RC_W-1:0]     rcnt;
  logic [1:0]          pwm_prev;
  logic [15:0]         lfsr;
  logic                lfsr_fb;
  logic                match;
  logic                detect;

  // LFSR word sign-extended/truncated to the sample width, then scaled down.
  function automatic logic signed [T_BITS-1:0] dith_shape(input logic [15:0] r);
    logic signed [T_BITS-1:0] w;
    w = T_BITS'($signed(r));
    return w >>> DITH_SHIFT;
  endfunction

  // An osr of zero is treated as one, i.e. a reload value of zero.
  assign osr_m1  = (osr == '0) ? '0 : osr - OSR_BITS'(1);
  assign s_ready = (state == S_LOAD) || ((state == S_RUN) && (cnt == '0));
  assign lfsr_fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
  assign match   = (pwm == pwm_prev) && (pwm != 2'b00);
  assign detect  = (state == S_RUN) &&
                   ((pwm == 2'b10) || (match && (runlen == RL_W'(STALL_LIM - 1))));

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      runlen      <= '0;
      rcnt        <= '0;
      pwm_prev    <= 2'b00;
      lfsr        <= 16'hACE1;
      vin         <= '0;
      dith        <= '0;
      dsm_reset   <= 1'b1;
      sample_tick <= 1'b0;
      underrun    <= 1'b0;
      overload    <= 1'b0;
    end else begin
      lfsr        <= {lfsr_fb, lfsr[15:1]};
      dith        <= dith_en ? dith_shape(lfsr) : '0;
      pwm_prev    <= pwm;
      sample_tick <= 1'b0;
      underrun    <= 1'b0;
      runlen      <= '0;

      // A fresh detection beats a simultaneous clear; en=0 suppresses detection.
      if (en && detect)
        overload <= 1'b1;
      else if (ovl_clr)
        overload <= 1'b0;

      if (!en) begin
        state     <= S_IDLE;
        vin       <= '0;
        cnt       <= '0;
        rcnt      <= '0;
        dsm_reset <= 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            state     <= S_LOAD;
            dsm_reset <= 1'b1;
          end
          S_LOAD: begin
            if (s_valid) begin
              vin         <= s_data;
              sample_tick <= 1'b1;
              cnt         <= osr_m1;
              state       <= S_RUN;
              dsm_reset   <= 1'b0;
            end
          end
          S_RUN: begin
            if (cnt == '0) begin
              cnt <= osr_m1;
              if (s_valid) begin
                vin         <= s_data;
                sample_tick <= 1'b1;
              end else begin
                underrun <= 1'b1;
              end
            end else begin
              cnt <= cnt - OSR_BITS'(1);
            end
            if (detect) begin
              state     <= S_RECOVER;
              dsm_reset <= 1'b1;
              rcnt      <= RC_W'(RECOVER_CYC - 1);
            end else if (match) begin
              runlen <= runlen + RL_W'(1);
            end
          end
          default: begin
            if (rcnt == '0)
              state <= S_LOAD;
            else
              rcnt <= rcnt - RC_W'(1);
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dsm_ctrl.sv
`timescale 1ns/1ps
// Directed bench for dsm_ctrl: pacing, underrun, overload recovery, dither sequence and enable/reset priority.
module tb_dsm_ctrl;

  logic               clock = 1'b0;
  logic               reset;
  logic               en;
  logic [7:0]         osr;
  logic               s_valid;
  logic signed [15:0] s_data;
  logic               s_ready;
  logic               dith_en;
  logic [1:0]         pwm;
  logic               ovl_clr;
  logic signed [15:0] vin;
  logic signed [15:0] dith;
  logic               dsm_reset;
  logic               sample_tick;
  logic               underrun;
  logic               overload;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  dsm_ctrl dut (
    .clock(clock), .reset(reset), .en(en), .osr(osr),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .dith_en(dith_en), .pwm(pwm), .ovl_clr(ovl_clr),
    .vin(vin), .dith(dith), .dsm_reset(dsm_reset),
    .sample_tick(sample_tick), .underrun(underrun), .overload(overload)
  );

  // Reference for x^16+x^14+x^13+x^11+1, shifting toward bit 0.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    logic b;
    b = s[0] ^ s[2] ^ s[3] ^ s[5];
    return {b, s[15:1]};
  endfunction

  function automatic logic [15:0] dith_ref(input logic [15:0] s);
    logic signed [15:0] t;
    t = s;
    return t >>> 10;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b1; osr = 8'd4; s_valid = 1'b1; s_data = 16'sh1234;
    dith_en = 1'b1; pwm = 2'b10; ovl_clr = 1'b0;
    repeat (3) step();
    checks++; if (vin !== 16'h0000) begin errors++; $display("FAIL reset_vin got %h exp 0000", vin); end
    checks++; if (dith !== 16'h0000) begin errors++; $display("FAIL reset_dith got %h exp 0000", dith); end
    checks++; if ({dsm_reset, s_ready, overload, sample_tick, underrun} !== 5'b10000) begin
      errors++; $display("FAIL reset_ctrl got %b exp 10000", {dsm_reset, s_ready, overload, sample_tick, underrun});
    end
  endtask

  task automatic test_dither();
    logic [15:0] s;
    int bad;
    en = 1'b0; s_valid = 1'b0; pwm = 2'b00;
    reset = 1'b0;
    step();
    checks++; if (dith !== 16'hFFEB) begin errors++; $display("FAIL dith_first got %h exp FFEB", dith); end
    s = lfsr_step(16'hACE1);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (dith !== dith_ref(s)) bad++;
      s = lfsr_step(s);
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL dith_seq got %0d bad exp 0", bad); end
    dith_en = 1'b0;
    step();
    checks++; if (dith !== 16'h0000) begin errors++; $display("FAIL dith_off got %h exp 0000", dith); end
  endtask

  task automatic test_basic();
    en = 1'b1; osr = 8'd4; s_valid = 1'b1; s_data = 16'sh0100;
    step();
    checks++; if ({s_ready, dsm_reset} !== 2'b11) begin errors++; $display("FAIL load_state got %b exp 11", {s_ready, dsm_reset}); end
    step();
    checks++; if (vin !== 16'h0100 || sample_tick !== 1'b1 || dsm_reset !== 1'b0) begin
      errors++; $display("FAIL first_accept got vin=%h tick=%b rst=%b exp 0100 1 0", vin, sample_tick, dsm_reset);
    end
    for (int p = 0; p < 2; p++) begin
      s_data = (p == 0) ? 16'sh0200 : 16'sh0300;
      for (int k = 1; k <= 4; k++) begin
        step();
        checks++; if (s_ready !== (k == 3) || sample_tick !== (k == 4)) begin
          errors++; $display("FAIL pace p%0d k%0d got ready=%b tick=%b", p, k, s_ready, sample_tick);
        end
      end
      checks++; if (vin !== s_data) begin errors++; $display("FAIL pace_vin got %h exp %h", vin, s_data); end
    end
  endtask

  task automatic test_underrun();
    s_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      checks++; if (underrun !== (k == 4) || sample_tick !== (k == 8)) begin
        errors++; $display("FAIL underrun k%0d got und=%b tick=%b", k, underrun, sample_tick);
      end
      if (k == 4) begin
        checks++; if (vin !== 16'h0300) begin errors++; $display("FAIL underrun_hold got %h exp 0300", vin); end
        s_valid = 1'b1; s_data = 16'sh0400;
      end
    end
    checks++; if (vin !== 16'h0400) begin errors++; $display("FAIL after_underrun got %h exp 0400", vin); end
  endtask

  task automatic test_osr0();
    osr = 8'd0;
    for (int k = 1; k <= 4; k++) begin
      step();
      checks++; if (sample_tick !== (k == 4)) begin errors++; $display("FAIL osr_change k%0d got tick=%b", k, sample_tick); end
    end
    for (int k = 0; k < 5; k++) begin
      s_data = 16'sh0500 + 16'(k);
      checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL osr0_ready k%0d got %b exp 1", k, s_ready); end
      step();
      checks++; if (sample_tick !== 1'b1 || vin !== 16'h0500 + 16'(k)) begin
        errors++; $display("FAIL osr0_accept k%0d got tick=%b vin=%h", k, sample_tick, vin);
      end
    end
  endtask

  task automatic test_en_drop();
    s_data = 16'sh7777;
    en = 1'b0;
    step();
    checks++; if (vin !== 16'h0000 || sample_tick !== 1'b0 || s_ready !== 1'b0 || dsm_reset !== 1'b1) begin
      errors++; $display("FAIL en_drop got vin=%h tick=%b ready=%b rst=%b", vin, sample_tick, s_ready, dsm_reset);
    end
  endtask

  task automatic test_stall();
    int bad;
    en = 1'b1; osr = 8'd4; s_valid = 1'b1; s_data = 16'sh0100; pwm = 2'b01;
    step();
    step();
    bad = 0;
    for (int n = 1; n <= 63; n++) begin
      step();
      if (overload !== 1'b0 || dsm_reset !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL stall_early got %0d bad exp 0", bad); end
    step();
    pwm = 2'b00;
    checks++; if (overload !== 1'b1) begin errors++; $display("FAIL stall_detect got %b exp 1", overload); end
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) step();
      if (dsm_reset !== 1'b1 || s_ready !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL recover_len got %0d bad exp 0", bad); end
    step();
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL recover_to_load got %b exp 1", s_ready); end
  endtask

  task automatic test_illegal();
    ovl_clr = 1'b1;
    step();
    ovl_clr = 1'b0;
    checks++; if (overload !== 1'b0) begin errors++; $display("FAIL ovl_clr got %b exp 0", overload); end
    pwm = 2'b10;
    step();
    pwm = 2'b00;
    checks++; if (overload !== 1'b1 || s_ready !== 1'b0 || dsm_reset !== 1'b1) begin
      errors++; $display("FAIL illegal_pwm got ovl=%b ready=%b rst=%b exp 1 0 1", overload, s_ready, dsm_reset);
    end
    repeat (8) step();
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL illegal_recover got %b exp 1", s_ready); end
  endtask

  task automatic test_ovl_race();
    step();
    pwm = 2'b10; ovl_clr = 1'b1;
    step();
    pwm = 2'b00;
    checks++; if (overload !== 1'b1 || s_ready !== 1'b0) begin
      errors++; $display("FAIL ovl_race got ovl=%b ready=%b exp 1 0", overload, s_ready);
    end
    step();
    ovl_clr = 1'b0;
    checks++; if (overload !== 1'b0) begin errors++; $display("FAIL ovl_clr2 got %b exp 0", overload); end
    repeat (7) step();
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL race_recover got %b exp 1", s_ready); end
  endtask

  task automatic test_reset_mid();
    s_data = 16'sh0ABC;
    step();
    step();
    pwm = 2'b10;
    reset = 1'b1;
    step();
    checks++; if (vin !== 16'h0000 || s_ready !== 1'b0 || dsm_reset !== 1'b1 || overload !== 1'b0) begin
      errors++; $display("FAIL reset_mid got vin=%h ready=%b rst=%b ovl=%b", vin, s_ready, dsm_reset, overload);
    end
    reset = 1'b0; pwm = 2'b00;
    step();
    checks++; if (s_ready !== 1'b1 || vin !== 16'h0000) begin
      errors++; $display("FAIL reset_release got ready=%b vin=%h exp 1 0000", s_ready, vin);
    end
  endtask

  initial begin
    test_reset();
    test_dither();
    test_basic();
    test_underrun();
    test_osr0();
    test_en_drop();
    test_stall();
    test_illegal();
    test_ovl_race();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dsm_ctrl.md
DSM_CTRL -- requirements
Module: dsm_ctrl

Interface
REQ-001 SHALL have parameter T_BITS, default 16: width of sample and dither words (matches modulator word width).
REQ-002 SHALL have parameter OSR_BITS, default 8: width of the oversampling-ratio input.
REQ-003 SHALL have parameter STALL_LIM, default 64: number of consecutive identical nonzero pwm codes that declares loop overload.
REQ-004 SHALL have parameter RECOVER_CYC, default 8: number of cycles dsm_reset is held during overload recovery.
REQ-005 SHALL have parameter DITH_SHIFT, default 10: arithmetic right shift applied to the LFSR word to form dither.
REQ-006 Clock and reset: one clock; reset is synchronous and active-high. Ports SHALL be as follows.
- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous active-high reset.
- en  in  1  run enable.
- osr  in  OSR_BITS  modulator clocks per input sample; value 0 SHALL be treated as 1.
- s_valid  in  1  upstream sample valid.
- s_data  in  T_BITS  upstream sample, two's complement.
- s_ready  out  1  sample accepted this cycle when s_valid is also 1.
- dith_en  in  1  dither enable.
- pwm  in  2  modulator output code: 00 = 0, 01 = +1, 11 = -1, 10 = illegal.
- ovl_clr  in  1  clears the sticky overload flag.
- vin  out  T_BITS  registered sample driven to the modulator.
- dith  out  T_BITS  registered dither driven to the modulator.
- dsm_reset  out  1  reset to the modulator.
- sample_tick  out  1  one-cycle pulse in the cycle vin takes a new sample.
- underrun  out  1  one-cycle pulse when a sample slot passes with no data.
- overload  out  1  sticky overload flag.

Function
REQ-007 The FSM SHALL have four states: IDLE, LOAD, RUN and RECOVER.
REQ-008 In IDLE: s_ready=0, dsm_reset=1, vin=0. The FSM SHALL go to LOAD when en=1.
REQ-009 In LOAD: s_ready=1, dsm_reset=1. On s_valid=1, the FSM SHALL capture s_data into vin, load cnt with osr_eff-1, and go to RUN.
REQ-010 In RUN, dsm_reset SHALL be 0 and cnt SHALL decrement each cycle.
REQ-011 In RUN, s_ready SHALL be 1 only in the cycle where cnt==0.
REQ-012 In RUN, when cnt==0: cnt SHALL reload to osr_eff-1. If s_valid=1, vin SHALL load s_data. If s_valid=0, vin SHALL hold and underrun SHALL pulse next cycle.
REQ-013 Every vin update SHALL be visible the cycle after the accept, with sample_tick=1 in that same cycle.
REQ-014 When osr_eff=1, the block SHALL accept a sample every cycle in RUN.
REQ-015 A change to osr SHALL take effect at the next cnt reload only.
REQ-016 The overload monitor SHALL be active in RUN only: runlen increments when pwm equals its previous-cycle value and is nonzero, and clears otherwise.
REQ-017 When runlen reaches STALL_LIM-1 and the next matching code arrives, or when pwm=10 is seen, the FSM SHALL set overload=1 and go to RECOVER.
REQ-018 In RECOVER: dsm_reset=1, s_ready=0, vin held. After exactly RECOVER_CYC cycles the FSM SHALL go to LOAD.
REQ-019 en=0 in any state SHALL force IDLE on the next edge, with vin=0 and cnt=0.
REQ-020 en=0 SHALL take priority over a simultaneous accept or overload detection.
REQ-021 overload SHALL clear only on reset or ovl_clr=1; if a new detection and ovl_clr=1 occur in the same cycle, detection wins and overload stays 1.
REQ-022 The LFSR SHALL be 16 bits, Fibonacci form, polynomial x^16+x^14+x^13+x^11+1, and advance every non-reset cycle.
REQ-023 dith SHALL be the LFSR value, sign-extended or truncated to T_BITS, arithmetically shifted right by DITH_SHIFT, registered, and forced to 0 when dith_en=0.
REQ-024 All outputs SHALL be registered except s_ready, which SHALL be decoded from state and cnt.

Reset
REQ-025 On reset=1: state=IDLE, vin=0, dith=0, cnt=0, runlen=0, overload=0, sample_tick=0, underrun=0, dsm_reset=1, s_ready=0, and LFSR=16'hACE1.
REQ-026 Reset SHALL override en and all inputs.
REQ-027 Reset asserted mid-RUN or mid-RECOVER SHALL discard the in-flight sample and the recovery count.

Verification
REQ-028 Setup en=1, osr=4, s_valid always 1, s_data=0x0100 then 0x0200 -> accepts spaced 4 cycles apart, vin=0x0100 then 0x0200, and sample_tick every 4th cycle.
REQ-029 Setup osr=4, s_valid dropped for one slot -> underrun pulses once, vin holds its value, and the next accept comes 4 cycles later.
REQ-030 Setup pwm held at 01 for 64 cycles in RUN -> overload=1, dsm_reset=1 for exactly 8 cycles, then LOAD with s_ready=1.
REQ-031 Setup pwm=10 for a single cycle -> immediate RECOVER.
REQ-032 Setup ovl_clr=1 together with a detection in the same cycle -> overload stays 1.
REQ-033 Setup en dropped in the same cycle as an accept -> IDLE next cycle, vin=0, and no sample_tick.
REQ-034 Setup dith_en=1 after reset -> the first dith value equals 16'hACE1 >>> 10 (0xFFEB), and the dith sequence matches the polynomial reference model; with dith_en=0, dith=0.
REQ-035 Setup osr=0 -> behaves as osr=1, with s_ready=1 every RUN cycle.
